fetch_res_buffer: RTL and testbench
===================================

# fetch_res_buffer

Parametrised fetch-result buffer between the instruction-memory response and decode. Each accepted fetch response is aligned to the fetch-block base, given a per-slot valid mask from the PC offset, and stored with its branch-prediction pack in a DEPTH-entry FIFO. Decode drains the FIFO through a valid/ready handshake. A flush empties the buffer in one cycle.

## Interface
Parameters:
- FETCH_WIDTH, 2: instructions per fetch block; power of two, 1..8.
- DEPTH, 4: buffer entries; power of two, at least 2.
- XLEN, 64: PC and branch-target width.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_i_flush  in  1  flush the buffer and drop the current input.
- io_i_fetch_valid  in  1  fetch response present.
- io_o_fetch_ready  out  1  buffer can accept a response.
- io_i_pc  in  XLEN  PC of the first requested instruction.
- io_i_fetch_res  in  FETCH_WIDTH*32  fetch block; slot k is bits [32k+31:32k].
- io_i_branch_predict_pack_valid  in  1  BP pack valid.
- io_i_branch_predict_pack_target  in  XLEN  BP target.
- io_i_branch_predict_pack_taken  in  1  BP taken.
- io_o_fetch_pack_valid  out  1  head entry available.
- io_i_fetch_pack_ready  in  1  decode accepts the head entry.
- io_o_fetch_pack_bits_valids  out  FETCH_WIDTH  per-slot valid mask.
- io_o_fetch_pack_bits_pc  out  XLEN  aligned block PC.
- io_o_fetch_pack_bits_insts  out  FETCH_WIDTH*32  instructions.
- io_o_fetch_pack_bits_branch_predict_pack_{valid,target,taken}  out  1/XLEN/1  stored BP pack.

## Operation
- OFS = log2(FETCH_WIDTH) bits, io_i_pc[OFS+1:2]. Aligned PC = io_i_pc with bits [OFS+1:0] cleared.
- Slot k is valid iff k >= OFS and no flush is active. For FETCH_WIDTH=1 the mask is always 1.
- enq = io_i_fetch_valid & io_o_fetch_ready & ~io_i_flush.
- deq = io_o_fetch_pack_valid & io_i_fetch_pack_ready & ~io_i_flush.
- io_o_fetch_ready = (count != DEPTH). It does not depend on deq in the same cycle.
- io_o_fetch_pack_valid = (count != 0). All output bits come from the head entry. Outputs are don't-care when valid is 0, but the valids field is forced to 0 in that case.
- Pointers head and tail are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance, including at count == 1.
- Flush: head, tail and count are cleared at the next edge. Input in the flush cycle is dropped, and io_o_fetch_pack_valid is forced to 0 combinationally in that cycle.
- Entry payload storage is not reset. Only pointers and count are reset.

## Timing
- Reset (reset low, asynchronous): count=0, head=0, tail=0. Therefore io_o_fetch_pack_valid=0, io_o_fetch_ready=1, valids=0.
- Enqueue-to-output latency is 1 cycle: data accepted at edge N is visible after edge N.
- Full (count=DEPTH): ready=0 and input is held by the producer. Ready rises the cycle after a dequeue.
- Empty: valid=0. A dequeue request is ignored.
- Reset asserted mid-operation discards all entries immediately, with no partial state.

## Configuration
- FETCH_RES_BYPASS_EN defined:
  - When count==0 and enq, the input passes combinationally to the outputs in the same cycle.
  - If deq also occurs that cycle, nothing is written.
  - Otherwise the entry is written as normal.
  - io_o_fetch_ready is unchanged.
- FETCH_RES_BYPASS_EN undefined: strict 1-cycle latency as above.

## Structure
- Package fetch_pkg holds:
  - INST_W=32.
  - bp_pack_t (valid, target, taken).
  - fetch_pack_t (valids, pc, insts, bp).
  - Function valid_mask(ofs).
- One sub-module, fetch_res_fifo: a generic DEPTH-entry pointer FIFO with flush, storing fetch_pack_t.
- fetch_res_buffer contains the alignment/mask logic plus the optional bypass.

## Test plan
- Reset, then enqueue pc=0x8000_0004 with fetch_res=0x11111111_22222222 (FETCH_WIDTH=2) -> next cycle pc=0x8000_0000, valids=2'b10, insts_0=0x22222222, insts_1=0x11111111.
- Fill 4 entries with io_i_fetch_pack_ready=0 -> ready=0 after the 4th; a 5th input is not accepted. Dequeue one -> ready=1 the next cycle; order is preserved FIFO.
- Count=1 with simultaneous enq and deq -> count stays 1; output is the new entry next cycle.
- Count=3, flush with io_i_fetch_valid=1 -> valid=0 in that cycle; count=0 next cycle; the input is not stored.
- Pointer wrap: enqueue and dequeue 10 blocks with pc=0x1000+8i -> outputs pc=0x1000+8i in order with BP packs intact.
- With FETCH_RES_BYPASS_EN, empty buffer with enq and deq in the same cycle, pc=0x20 -> valid=1 that cycle with pc=0x20, count remains 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and helpers for the fetch-result buffer
//
// Contents:
//   INST_W          instruction width in bits
//   FP_FETCH_WIDTH  instructions per fetch block the pack types are built for
//   FP_XLEN         PC / branch-target width the pack types are built for
//   FP_OFS_W        width of the in-block slot offset (at least 1)
//   bp_pack_t       branch-prediction pack {valid, target, taken}
//   fetch_pack_t    buffered entry {valids, pc, insts, bp}
//   valid_mask()    per-slot valid mask from the slot offset

package fetch_pkg;

  localparam int INST_W         = 32;
  localparam int FP_FETCH_WIDTH = 2;
  localparam int FP_XLEN        = 64;
  localparam int FP_OFS_W       = (FP_FETCH_WIDTH > 1) ? $clog2(FP_FETCH_WIDTH) : 1;

  typedef struct packed {
    logic               valid;
    logic [FP_XLEN-1:0] target;
    logic               taken;
  } bp_pack_t;

  typedef struct packed {
    logic [FP_FETCH_WIDTH-1:0]        valids;
    logic [FP_XLEN-1:0]               pc;
    logic [FP_FETCH_WIDTH*INST_W-1:0] insts;
    bp_pack_t                         bp;
  } fetch_pack_t;

  // Slots below the requested offset belong to the previous block and are
  // masked off; with one slot per block the offset is always 0.
  function automatic logic [FP_FETCH_WIDTH-1:0] valid_mask(input logic [FP_OFS_W-1:0] ofs);
    logic [FP_FETCH_WIDTH-1:0] m;
    for (int k = 0; k < FP_FETCH_WIDTH; k++) begin
      m[k] = (k >= int'(ofs));
    end
    return m;
  endfunction

endpackage

// File: rtl/fetch_res_fifo.sv
// rtl/fetch_res_fifo.sv - DEPTH-entry pointer FIFO of fetch_pack_t with flush
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-low reset
//   flush          clears pointers and count at the next edge, drops push/pop
//   push/push_data write push_data at tail (ignored when full)
//   pop            advance head (ignored when empty)
//   head_data      entry at head (stale when count is 0)
//   count          occupancy, 0..DEPTH

module fetch_res_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_pack_t              push_data,
  input  logic                     pop,
  output fetch_pack_t              head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_pack_t   mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok   = push & (count != (PW+1)'(DEPTH)) & ~flush;
  assign pop_ok    = pop & (count != '0) & ~flush;
  assign head_data = mem[head];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload is never reset; pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (push_ok) mem[tail] <= push_data;
  end

endmodule

// File: rtl/fetch_res_buffer.sv
// rtl/fetch_res_buffer.sv - aligns fetch responses and buffers them for decode
//
// Optional feature macro: FETCH_RES_BYPASS_EN (empty-buffer same-cycle bypass).
// FETCH_WIDTH and XLEN must match FP_FETCH_WIDTH / FP_XLEN in fetch_pkg.
//
// Ports:
//   clock, reset                       clock, asynchronous active-low reset
//   io_i_flush                         empty the buffer, drop current input
//   io_i_fetch_valid/io_o_fetch_ready  fetch response handshake
//   io_i_pc, io_i_fetch_res            requested PC and fetch block
//   io_i_branch_predict_pack_*         branch-prediction pack for the block
//   io_o_fetch_pack_valid/io_i_fetch_pack_ready  decode handshake
//   io_o_fetch_pack_bits_*             head entry (valids forced 0 when idle)

module fetch_res_buffer
  import fetch_pkg::*;
#(
  parameter int FETCH_WIDTH = FP_FETCH_WIDTH,
  parameter int DEPTH       = 4,
  parameter int XLEN        = FP_XLEN
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_i_flush,
  input  logic                     io_i_fetch_valid,
  output logic                     io_o_fetch_ready,
  input  logic [XLEN-1:0]          io_i_pc,
  input  logic [FETCH_WIDTH*32-1:0] io_i_fetch_res,
  input  logic                     io_i_branch_predict_pack_valid,
  input  logic [XLEN-1:0]          io_i_branch_predict_pack_target,
  input  logic                     io_i_branch_predict_pack_taken,
  output logic                     io_o_fetch_pack_valid,
  input  logic                     io_i_fetch_pack_ready,
  output logic [FETCH_WIDTH-1:0]   io_o_fetch_pack_bits_valids,
  output logic [XLEN-1:0]          io_o_fetch_pack_bits_pc,
  output logic [FETCH_WIDTH*32-1:0] io_o_fetch_pack_bits_insts,
  output logic                     io_o_fetch_pack_bits_branch_predict_pack_valid,
  output logic [XLEN-1:0]          io_o_fetch_pack_bits_branch_predict_pack_target,
  output logic                     io_o_fetch_pack_bits_branch_predict_pack_taken
);

  localparam int OFS_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int LOW_W = $clog2(FETCH_WIDTH) + 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] LOW_MASK = (XLEN'(1) << LOW_W) - XLEN'(1);

  logic [OFS_W-1:0] ofs;
  logic [CNT_W-1:0] count;
  fetch_pack_t      in_pack;
  fetch_pack_t      head_pack;
  fetch_pack_t      out_pack;
  logic             enq;
  logic             deq;
  logic             bypass;
  logic             out_valid;

  if (FETCH_WIDTH > 1) begin : g_ofs
    assign ofs = io_i_pc[LOW_W-1:2];
  end else begin : g_ofs_none
    assign ofs = '0;
  end

  always_comb begin
    in_pack           = '0;
    in_pack.valids    = io_i_flush ? '0 : valid_mask(ofs);
    in_pack.pc        = io_i_pc & ~LOW_MASK;
    in_pack.insts     = io_i_fetch_res;
    in_pack.bp.valid  = io_i_branch_predict_pack_valid;
    in_pack.bp.target = io_i_branch_predict_pack_target;
    in_pack.bp.taken  = io_i_branch_predict_pack_taken;
  end

  // Ready looks only at occupancy so it never combinationally depends on decode.
  assign io_o_fetch_ready = (count != CNT_W'(DEPTH));
  assign enq              = io_i_fetch_valid & io_o_fetch_ready & ~io_i_flush;

`ifdef FETCH_RES_BYPASS_EN
  assign bypass = enq & (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = ((count != '0) | bypass) & ~io_i_flush;
  assign out_pack  = bypass ? in_pack : head_pack;
  assign deq       = out_valid & io_i_fetch_pack_ready;

  // A bypassed block that decode takes immediately never touches storage,
  // and a bypass cycle never pops because the stored queue is empty.
  fetch_res_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (io_i_flush),
    .push      (enq & ~(bypass & deq)),
    .push_data (in_pack),
    .pop       (deq & ~bypass),
    .head_data (head_pack),
    .count     (count)
  );

  assign io_o_fetch_pack_valid                           = out_valid;
  assign io_o_fetch_pack_bits_valids                     = out_valid ? out_pack.valids : '0;
  assign io_o_fetch_pack_bits_pc                         = out_pack.pc;
  assign io_o_fetch_pack_bits_insts                      = out_pack.insts;
  assign io_o_fetch_pack_bits_branch_predict_pack_valid  = out_pack.bp.valid;
  assign io_o_fetch_pack_bits_branch_predict_pack_target = out_pack.bp.target;
  assign io_o_fetch_pack_bits_branch_predict_pack_taken  = out_pack.bp.taken;

endmodule

// File: tb/tb_fetch_res_buffer.sv
// tb/tb_fetch_res_buffer.sv - scoreboard bench for fetch_res_buffer

module tb_fetch_res_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_i_flush;
  logic        io_i_fetch_valid;
  logic        io_o_fetch_ready;
  logic [63:0] io_i_pc;
  logic [63:0] io_i_fetch_res;
  logic        io_i_branch_predict_pack_valid;
  logic [63:0] io_i_branch_predict_pack_target;
  logic        io_i_branch_predict_pack_taken;
  logic        io_o_fetch_pack_valid;
  logic        io_i_fetch_pack_ready;
  logic [1:0]  io_o_fetch_pack_bits_valids;
  logic [63:0] io_o_fetch_pack_bits_pc;
  logic [63:0] io_o_fetch_pack_bits_insts;
  logic        io_o_fetch_pack_bits_branch_predict_pack_valid;
  logic [63:0] io_o_fetch_pack_bits_branch_predict_pack_target;
  logic        io_o_fetch_pack_bits_branch_predict_pack_taken;

  always #5 clock = ~clock;

  fetch_res_buffer #(.FETCH_WIDTH(2), .DEPTH(4), .XLEN(64)) dut (
    .clock                                           (clock),
    .reset                                           (reset),
    .io_i_flush                                      (io_i_flush),
    .io_i_fetch_valid                                (io_i_fetch_valid),
    .io_o_fetch_ready                                (io_o_fetch_ready),
    .io_i_pc                                         (io_i_pc),
    .io_i_fetch_res                                  (io_i_fetch_res),
    .io_i_branch_predict_pack_valid                  (io_i_branch_predict_pack_valid),
    .io_i_branch_predict_pack_target                 (io_i_branch_predict_pack_target),
    .io_i_branch_predict_pack_taken                  (io_i_branch_predict_pack_taken),
    .io_o_fetch_pack_valid                           (io_o_fetch_pack_valid),
    .io_i_fetch_pack_ready                           (io_i_fetch_pack_ready),
    .io_o_fetch_pack_bits_valids                     (io_o_fetch_pack_bits_valids),
    .io_o_fetch_pack_bits_pc                         (io_o_fetch_pack_bits_pc),
    .io_o_fetch_pack_bits_insts                      (io_o_fetch_pack_bits_insts),
    .io_o_fetch_pack_bits_branch_predict_pack_valid  (io_o_fetch_pack_bits_branch_predict_pack_valid),
    .io_o_fetch_pack_bits_branch_predict_pack_target (io_o_fetch_pack_bits_branch_predict_pack_target),
    .io_o_fetch_pack_bits_branch_predict_pack_taken  (io_o_fetch_pack_bits_branch_predict_pack_taken)
  );

  typedef struct {
    logic [1:0]  valids;
    logic [63:0] pc;
    logic [63:0] insts;
    logic        bpv;
    logic [63:0] bpt;
    logic        bpk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic neg();
    @(negedge clock);
  endtask

  task automatic idle();
    io_i_fetch_valid                = 1'b0;
    io_i_pc                         = '0;
    io_i_fetch_res                  = '0;
    io_i_branch_predict_pack_valid  = 1'b0;
    io_i_branch_predict_pack_target = '0;
    io_i_branch_predict_pack_taken  = 1'b0;
  endtask

  task automatic send(input logic [63:0] pc, input logic [63:0] res, input logic bpv,
                      input logic [63:0] bpt, input logic bpk);
    io_i_fetch_valid                = 1'b1;
    io_i_pc                         = pc;
    io_i_fetch_res                  = res;
    io_i_branch_predict_pack_valid  = bpv;
    io_i_branch_predict_pack_target = bpt;
    io_i_branch_predict_pack_taken  = bpk;
  endtask

  task automatic expect_out(input logic [1:0] valids, input logic [63:0] pc, input logic [63:0] insts,
                            input logic bpv, input logic [63:0] bpt, input logic bpk);
    exp_t e;
    e.valids = valids;
    e.pc     = pc;
    e.insts  = insts;
    e.bpv    = bpv;
    e.bpt    = bpt;
    e.bpk    = bpk;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted head entry is checked against the next expected one.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && io_o_fetch_pack_valid && io_i_fetch_pack_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got pc %h expected no output", io_o_fetch_pack_bits_pc);
        end else begin
          e = exp_q.pop_front();
          check("out_pc",     io_o_fetch_pack_bits_pc, e.pc);
          check("out_valids", 64'(io_o_fetch_pack_bits_valids), 64'(e.valids));
          check("out_insts",  io_o_fetch_pack_bits_insts, e.insts);
          check("out_bp_valid",  64'(io_o_fetch_pack_bits_branch_predict_pack_valid), 64'(e.bpv));
          check("out_bp_target", io_o_fetch_pack_bits_branch_predict_pack_target, e.bpt);
          check("out_bp_taken",  64'(io_o_fetch_pack_bits_branch_predict_pack_taken), 64'(e.bpk));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    reset                 = 1'b0;
    io_i_flush            = 1'b0;
    io_i_fetch_pack_ready = 1'b0;
    idle();

    // Reset state
    neg();
    check("rst_valid",  64'(io_o_fetch_pack_valid), 64'd0);
    check("rst_ready",  64'(io_o_fetch_ready), 64'd1);
    check("rst_valids", 64'(io_o_fetch_pack_bits_valids), 64'd0);
    nxt();
    reset = 1'b1;
    nxt();

    // Alignment and mask: pc offset 1 within a 2-slot block
    send(64'h8000_0004, 64'h11111111_22222222, 1'b1, 64'h8000_0100, 1'b1);
    expect_out(2'b10, 64'h8000_0000, 64'h11111111_22222222, 1'b1, 64'h8000_0100, 1'b1);
    neg();
`ifndef FETCH_RES_BYPASS_EN
    check("lat_valid_before", 64'(io_o_fetch_pack_valid), 64'd0);
`endif
    nxt();
    idle();
    neg();
    check("lat_valid_after", 64'(io_o_fetch_pack_valid), 64'd1);
    check("lat_valids",      64'(io_o_fetch_pack_bits_valids), 64'h2);
    nxt();
    io_i_fetch_pack_ready = 1'b1;
    nxt();
    io_i_fetch_pack_ready = 1'b0;
    neg();
    check("t1_drained", 64'(io_o_fetch_pack_valid), 64'd0);
    nxt();

    // Fill to full, hold a 5th input, free one slot, then drain in order
    for (int i = 0; i < 4; i++) begin
      send(64'h2000 + 64'(8 * i) + 64'(4 * (i % 2)), {32'hC000_0000 | 32'(i), 32'hD000_0000 | 32'(i)},
           1'b1, 64'h7000 + 64'(i), 1'(i % 2));
      expect_out((i % 2) ? 2'b10 : 2'b11, 64'h2000 + 64'(8 * i),
                 {32'hC000_0000 | 32'(i), 32'hD000_0000 | 32'(i)}, 1'b1, 64'h7000 + 64'(i), 1'(i % 2));
      neg();
      check("fill_ready", 64'(io_o_fetch_ready), 64'd1);
      nxt();
    end
    send(64'h3000, 64'hEEEE_EEEE_5555_5555, 1'b0, 64'h3333, 1'b0);
    neg();
    check("full_ready", 64'(io_o_fetch_ready), 64'd0);
    nxt();
    io_i_fetch_pack_ready = 1'b1;
    neg();
    check("full_ready_during_deq", 64'(io_o_fetch_ready), 64'd0);
    nxt();
    io_i_fetch_pack_ready = 1'b0;
    neg();
    check("ready_after_deq", 64'(io_o_fetch_ready), 64'd1);
    expect_out(2'b11, 64'h3000, 64'hEEEE_EEEE_5555_5555, 1'b0, 64'h3333, 1'b0);
    nxt();
    idle();
    io_i_fetch_pack_ready = 1'b1;
    repeat (4) nxt();
    io_i_fetch_pack_ready = 1'b0;
    neg();
    check("fill_drained", 64'(io_o_fetch_pack_valid), 64'd0);
    nxt();

    // Dequeue request on an empty buffer is ignored
    io_i_fetch_pack_ready = 1'b1;
    neg();
    check("empty_deq_valid", 64'(io_o_fetch_pack_valid), 64'd0);
    nxt();
    io_i_fetch_pack_ready = 1'b0;

    // count == 1 with simultaneous enqueue and dequeue
    send(64'h4000, 64'hAAAA_0001_AAAA_0000, 1'b1, 64'h4400, 1'b0);
    expect_out(2'b11, 64'h4000, 64'hAAAA_0001_AAAA_0000, 1'b1, 64'h4400, 1'b0);
    nxt();
    send(64'h4014, 64'hBBBB_0001_BBBB_0000, 1'b0, 64'h4800, 1'b1);
    expect_out(2'b10, 64'h4010, 64'hBBBB_0001_BBBB_0000, 1'b0, 64'h4800, 1'b1);
    io_i_fetch_pack_ready = 1'b1;
    nxt();
    idle();
    io_i_fetch_pack_ready = 1'b0;
    neg();
    check("cnt1_valid", 64'(io_o_fetch_pack_valid), 64'd1);
    nxt();
    io_i_fetch_pack_ready = 1'b1;
    nxt();
    io_i_fetch_pack_ready = 1'b0;
    neg();
    check("cnt1_empty", 64'(io_o_fetch_pack_valid), 64'd0);
    nxt();

    // Flush at count 3 with a live input
    for (int i = 0; i < 3; i++) begin
      send(64'h5000 + 64'(8 * i), 64'h0F0F_0F0F_0000_0000 | 64'(i), 1'b1, 64'h5500, 1'b1);
      nxt();
    end
    send(64'h5100, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h5600, 1'b1);
    io_i_flush            = 1'b1;
    io_i_fetch_pack_ready = 1'b1;
    neg();
    check("flush_valid",  64'(io_o_fetch_pack_valid), 64'd0);
    check("flush_valids", 64'(io_o_fetch_pack_bits_valids), 64'd0);
    nxt();
    io_i_flush            = 1'b0;
    io_i_fetch_pack_ready = 1'b0;
    idle();
    neg();
    check("flush_cleared_valid", 64'(io_o_fetch_pack_valid), 64'd0);
    check("flush_cleared_ready", 64'(io_o_fetch_ready), 64'd1);
    nxt();
    send(64'h5204, 64'hCAFE_0001_CAFE_0000, 1'b1, 64'h5A00, 1'b0);
    expect_out(2'b10, 64'h5200, 64'hCAFE_0001_CAFE_0000, 1'b1, 64'h5A00, 1'b0);
    nxt();
    idle();
    io_i_fetch_pack_ready = 1'b1;
    nxt();
    io_i_fetch_pack_ready = 1'b0;
    neg();
    check("post_flush_single", 64'(io_o_fetch_pack_valid), 64'd0);
    nxt();

    // Pointer wrap: 10 blocks streamed through
    io_i_fetch_pack_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(64'h1000 + 64'(8 * i), {32'hA000_0000 | 32'(i), 32'hB000_0000 | 32'(i)},
           1'(i != 3), 64'h9000 + 64'(16 * i), 1'(i % 2));
      expect_out(2'b11, 64'h1000 + 64'(8 * i), {32'hA000_0000 | 32'(i), 32'hB000_0000 | 32'(i)},
                 1'(i != 3), 64'h9000 + 64'(16 * i), 1'(i % 2));
      nxt();
    end
    idle();
    nxt();
    nxt();
    io_i_fetch_pack_ready = 1'b0;
    neg();
    check("wrap_drained", 64'(io_o_fetch_pack_valid), 64'd0);
    nxt();

    // Asynchronous reset mid-operation
    send(64'h6000, 64'h6666_6666_6666_6666, 1'b1, 64'h6100, 1'b1);
    nxt();
    send(64'h6008, 64'h7777_7777_7777_7777, 1'b1, 64'h6200, 1'b0);
    nxt();
    idle();
    neg();
    check("pre_reset_valid", 64'(io_o_fetch_pack_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_valid", 64'(io_o_fetch_pack_valid), 64'd0);
    check("async_reset_ready", 64'(io_o_fetch_ready), 64'd1);
    nxt();
    reset = 1'b1;
    neg();
    check("post_reset_valid", 64'(io_o_fetch_pack_valid), 64'd0);
    nxt();

`ifdef FETCH_RES_BYPASS_EN
    // Bypass on an empty buffer with decode ready in the same cycle
    io_i_fetch_pack_ready = 1'b1;
    send(64'h20, 64'h0BAD_F00D_600D_F00D, 1'b1, 64'h40, 1'b1);
    expect_out(2'b11, 64'h20, 64'h0BAD_F00D_600D_F00D, 1'b1, 64'h40, 1'b1);
    neg();
    check("byp_valid", 64'(io_o_fetch_pack_valid), 64'd1);
    check("byp_pc",    io_o_fetch_pack_bits_pc, 64'h20);
    nxt();
    idle();
    io_i_fetch_pack_ready = 1'b0;
    neg();
    check("byp_count0", 64'(io_o_fetch_pack_valid), 64'd0);
    nxt();
`endif

    neg();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
